// File: rtl/aud_fade_router_if.sv
// ---------------------------------------------------------------------------
// aud_fade_router_if
//   Bundles the sample stream and control levels of aud_fade_router.
//   master : upstream source / testbench (drives samples and controls)
//   slave  : aud_fade_router (drives the scaled samples and route)
//
//   in_valid   1   one-cycle strobe, in_left/in_right hold a new sample
//   in_left    16  signed PCM left
//   in_right   16  signed PCM right
//   mute_req   1   level, 1 = fade to silence and stay there
//   hp_detect  1   level (already synchronous), 1 = headphones present
//   out_valid  1   one-cycle strobe, out_left/out_right updated
//   out_left   16  signed scaled left
//   out_right  16  signed scaled right
//   hp_route   1   route applied downstream, changes only at zero gain
//   muted      1   1 while state is MUTED or HOLD
// ---------------------------------------------------------------------------
interface aud_fade_router_if;
    logic        in_valid;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        mute_req;
    logic        hp_detect;
    logic        out_valid;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic        hp_route;
    logic        muted;

    modport master (
        output in_valid, in_left, in_right, mute_req, hp_detect,
        input  out_valid, out_left, out_right, hp_route, muted
    );

    modport slave (
        input  in_valid, in_left, in_right, mute_req, hp_detect,
        output out_valid, out_left, out_right, hp_route, muted
    );
endinterface

// File: rtl/aud_fade_router.sv
// ---------------------------------------------------------------------------
// aud_fade_router
//   Click/pop suppressor in front of the I2S serializer. Scales stereo PCM
//   by a linear gain that ramps between 0 and unity on mute requests, and on
//   headphone insert/remove fades out, flips the route while silent, holds
//   silence for HOLD_SAMPLES samples and fades back in.
//
//   gClk     in  audio clock, all logic on posedge
//   reset_n  in  asynchronous active-low reset
//   bus      slave modport of aud_fade_router_if (samples, controls, outputs)
//
//   Parameters: GAIN_BITS (gain fraction bits, unity = 2**GAIN_BITS),
//               RAMP_STEP (gain change per ramping sample),
//               HOLD_SAMPLES (zero-gain samples after a route flip, >= 1).
// ---------------------------------------------------------------------------
module aud_fade_router #(
    parameter int GAIN_BITS    = 8,
    parameter int RAMP_STEP    = 1,
    parameter int HOLD_SAMPLES = 4
) (
    input  logic               gClk,
    input  logic               reset_n,
    aud_fade_router_if.slave   bus
);

    localparam int GW     = GAIN_BITS + 1;
    localparam int PROD_W = 16 + GW;
    localparam int HOLD_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;

    localparam logic [GW-1:0]     UNITY_G   = GW'(1 << GAIN_BITS);
    localparam logic [GW-1:0]     STEP_G    = GW'(RAMP_STEP);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_SAMPLES - 1);

    typedef enum logic [2:0] {
        S_MUTED,
        S_HOLD,
        S_RAMP_UP,
        S_ACTIVE,
        S_RAMP_DOWN
    } state_e;

    state_e            state_q, state_d;
    logic [GW-1:0]     gain_q, gain_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              route_q, route_d;

    logic              out_valid_q;
    logic [15:0]       out_left_q, out_right_q;
    logic [15:0]       out_left_d, out_right_d;
    logic              muted;

    logic              want_down;
    logic [GW:0]       gain_up;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge gClk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_MUTED;
            gain_q     <= '0;
            hold_cnt_q <= '0;
            route_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gain_q     <= gain_d;
            hold_cnt_q <= hold_cnt_d;
            route_q    <= route_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic; everything holds on cycles without a new sample.
    // -----------------------------------------------------------------------
    assign want_down = bus.mute_req | (bus.hp_detect != route_q);
    assign gain_up   = {1'b0, gain_q} + {1'b0, STEP_G};

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        gain_d     = gain_q;
        hold_cnt_d = hold_cnt_q;
        route_d    = route_q;

        if (bus.in_valid) begin
            unique case (state_q)
                S_MUTED: begin
                    gain_d = '0;
                    // Route may only change here, where the output is silent.
                    if (bus.hp_detect != route_q) begin
                        route_d    = bus.hp_detect;
                        hold_cnt_d = HOLD_INIT;
                        state_d    = S_HOLD;
                    end else if (!bus.mute_req) begin
                        state_d = S_RAMP_UP;
                    end
                end

                S_HOLD: begin
                    gain_d = '0;
                    if (hold_cnt_q == '0) state_d = S_MUTED;
                    else                  hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end

                S_RAMP_UP: begin
                    // A reversal keeps the gain for one sample, so there is no jump.
                    if (want_down) begin
                        state_d = S_RAMP_DOWN;
                    end else if (gain_up >= {1'b0, UNITY_G}) begin
                        gain_d  = UNITY_G;
                        state_d = S_ACTIVE;
                    end else begin
                        gain_d = gain_up[GW-1:0];
                    end
                end

                S_ACTIVE: begin
                    gain_d = UNITY_G;
                    if (want_down) state_d = S_RAMP_DOWN;
                end

                S_RAMP_DOWN: begin
                    if (!want_down) begin
                        state_d = S_RAMP_UP;
                    end else if (gain_q <= STEP_G) begin
                        // Clamp at zero instead of wrapping the unsigned gain.
                        gain_d  = '0;
                        state_d = S_MUTED;
                    end else begin
                        gain_d = gain_q - STEP_G;
                    end
                end

                default: state_d = S_MUTED;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output logic: scaling uses the gain before this sample's update.
    // The shift is arithmetic (rounds toward -inf); gain <= unity so the
    // low 16 bits never overflow.
    // -----------------------------------------------------------------------
    always_comb begin
        logic signed [PROD_W-1:0] gain_s;
        logic signed [PROD_W-1:0] left_s;
        logic signed [PROD_W-1:0] right_s;

        gain_s  = {{(PROD_W-GW){1'b0}}, gain_q};
        left_s  = {{(PROD_W-16){bus.in_left[15]}},  bus.in_left};
        right_s = {{(PROD_W-16){bus.in_right[15]}}, bus.in_right};

        out_left_d  = 16'((left_s  * gain_s) >>> GAIN_BITS);
        out_right_d = 16'((right_s * gain_s) >>> GAIN_BITS);

        muted = (state_q == S_MUTED) || (state_q == S_HOLD);
    end

    // Output sample register, latency of one cycle after in_valid.
    // NOTE: only real state is reset here; there are no memories in this block.
    always_ff @(posedge gClk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_left_q  <= '0;
            out_right_q <= '0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                out_left_q  <= out_left_d;
                out_right_q <= out_right_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_left  = out_left_q;
    assign bus.out_right = out_right_q;
    assign bus.hp_route  = route_q;
    assign bus.muted     = muted;

endmodule

// File: tb/tb_aud_fade_router.sv
// ---------------------------------------------------------------------------
// tb_aud_fade_router
//   Drives two aud_fade_router instances (RAMP_STEP 1 and 4) with identical
//   stimulus. A small reference model predicts each sample's output, route
//   and muted flag into a scoreboard queue; a monitor compares every cycle.
//   Directed spot checks cover ramp start, unity, sign extension, reversal,
//   route flip timing and the asynchronous reset.
// ---------------------------------------------------------------------------
module tb_aud_fade_router;

    logic        gClk    = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid;
    logic [15:0] in_left, in_right;
    logic        mute_req, hp_detect;

    always #5 gClk = ~gClk;

    aud_fade_router_if bus0();
    aud_fade_router_if bus4();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_left   = in_left;
    assign bus0.in_right  = in_right;
    assign bus0.mute_req  = mute_req;
    assign bus0.hp_detect = hp_detect;
    assign bus4.in_valid  = in_valid;
    assign bus4.in_left   = in_left;
    assign bus4.in_right  = in_right;
    assign bus4.mute_req  = mute_req;
    assign bus4.hp_detect = hp_detect;

    aud_fade_router #(.GAIN_BITS(8), .RAMP_STEP(1), .HOLD_SAMPLES(4)) dut0 (
        .gClk(gClk), .reset_n(reset_n), .bus(bus0.slave)
    );
    aud_fade_router #(.GAIN_BITS(8), .RAMP_STEP(4), .HOLD_SAMPLES(4)) dut4 (
        .gClk(gClk), .reset_n(reset_n), .bus(bus4.slave)
    );

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        muted;
        logic        route;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb4[$];
    logic [15:0] log_l0[$];
    logic [15:0] log_r0[$];
    logic        log_m0[$];
    logic        log_rt0[$];
    logic [15:0] log_l4[$];

    int vectors     = 0;
    int miscompares = 0;

    localparam int M_MUTED = 0, M_HOLD = 1, M_UP = 2, M_ACT = 3, M_DOWN = 4;
    int   m_st[2];
    int   m_gain[2];
    int   m_hold[2];
    logic m_route[2];
    int   m_step[2] = '{1, 4};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k]    = M_MUTED;
            m_gain[k]  = 0;
            m_hold[k]  = 0;
            m_route[k] = 1'b0;
        end
    endtask

    // Reference behaviour for one accepted sample of instance k.
    task automatic model_push(input int k, input logic [15:0] l, input logic [15:0] r);
        exp_t e;
        int   pl, pr, tl, tr;
        logic wd;
        pl = int'($signed(l));
        pr = int'($signed(r));
        tl = (pl * m_gain[k]) >>> 8;
        tr = (pr * m_gain[k]) >>> 8;
        e.l = tl[15:0];
        e.r = tr[15:0];
        wd  = mute_req || (hp_detect != m_route[k]);
        case (m_st[k])
            M_MUTED: begin
                m_gain[k] = 0;
                if (hp_detect != m_route[k]) begin
                    m_route[k] = hp_detect;
                    m_hold[k]  = 3;
                    m_st[k]    = M_HOLD;
                end else if (!mute_req) m_st[k] = M_UP;
            end
            M_HOLD: begin
                if (m_hold[k] == 0) m_st[k] = M_MUTED;
                else m_hold[k] = m_hold[k] - 1;
            end
            M_UP: begin
                if (wd) m_st[k] = M_DOWN;
                else begin
                    m_gain[k] = m_gain[k] + m_step[k];
                    if (m_gain[k] >= 256) begin
                        m_gain[k] = 256;
                        m_st[k]   = M_ACT;
                    end
                end
            end
            M_ACT: if (wd) m_st[k] = M_DOWN;
            default: begin
                if (!wd) m_st[k] = M_UP;
                else begin
                    m_gain[k] = m_gain[k] - m_step[k];
                    if (m_gain[k] <= 0) begin
                        m_gain[k] = 0;
                        m_st[k]   = M_MUTED;
                    end
                end
            end
        endcase
        e.muted = (m_st[k] == M_MUTED) || (m_st[k] == M_HOLD);
        e.route = m_route[k];
        if (k == 0) sb0.push_back(e);
        else        sb4.push_back(e);
    endtask

    task automatic mon(input int k, input logic v, input logic [15:0] l, input logic [15:0] r,
                       input logic m, input logic rt);
        exp_t e;
        logic has;
        has = (k == 0) ? (sb0.size() != 0) : (sb4.size() != 0);
        chk($sformatf("dut%0d out_valid", k), {31'b0, v}, {31'b0, has});
        if (v && has) begin
            e = (k == 0) ? sb0.pop_front() : sb4.pop_front();
            chk($sformatf("dut%0d out_left", k),  {16'b0, l},  {16'b0, e.l});
            chk($sformatf("dut%0d out_right", k), {16'b0, r},  {16'b0, e.r});
            chk($sformatf("dut%0d muted", k),     {31'b0, m},  {31'b0, e.muted});
            chk($sformatf("dut%0d hp_route", k),  {31'b0, rt}, {31'b0, e.route});
            if (k == 0) begin
                log_l0.push_back(l);
                log_r0.push_back(r);
                log_m0.push_back(m);
                log_rt0.push_back(rt);
            end else begin
                log_l4.push_back(l);
            end
        end
    endtask

    // Monitor: sample 2 ns after every rising edge.
    always begin
        @(posedge gClk);
        #2;
        mon(0, bus0.out_valid, bus0.out_left, bus0.out_right, bus0.muted, bus0.hp_route);
        mon(1, bus4.out_valid, bus4.out_left, bus4.out_right, bus4.muted, bus4.hp_route);
    end

    task automatic clear_logs();
        log_l0.delete();
        log_r0.delete();
        log_m0.delete();
        log_rt0.delete();
        log_l4.delete();
    endtask

    // One sample, followed by `idle` extra idle cycles beyond the mandatory one.
    task automatic send(input logic [15:0] l, input logic [15:0] r, input int idle);
        @(negedge gClk);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        model_push(0, l, r);
        model_push(1, l, r);
        @(negedge gClk);
        in_valid = 1'b0;
        repeat (idle) @(negedge gClk);
    endtask

    // Back-to-back samples, in_valid high every cycle.
    task automatic stream(input logic [15:0] l, input logic [15:0] r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge gClk);
            in_valid = 1'b1;
            in_left  = l;
            in_right = r;
            model_push(0, l, r);
            model_push(1, l, r);
        end
        @(negedge gClk);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " dut0 out_valid"}, {31'b0, bus0.out_valid}, 32'd0);
        chk({tag, " dut0 out_left"},  {16'b0, bus0.out_left},  32'd0);
        chk({tag, " dut0 out_right"}, {16'b0, bus0.out_right}, 32'd0);
        chk({tag, " dut0 muted"},     {31'b0, bus0.muted},     32'd1);
        chk({tag, " dut0 hp_route"},  {31'b0, bus0.hp_route},  32'd0);
        chk({tag, " dut4 out_valid"}, {31'b0, bus4.out_valid}, 32'd0);
        chk({tag, " dut4 muted"},     {31'b0, bus4.muted},     32'd1);
        chk({tag, " dut4 hp_route"},  {31'b0, bus4.hp_route},  32'd0);
    endtask

    // Asynchronous reset pulse asserted between clock edges.
    task automatic reset_pulse(input string tag);
        @(posedge gClk);
        #4;
        reset_n = 1'b0;
        sb0.delete();
        sb4.delete();
        #1;
        check_reset_state(tag);
        model_reset();
        @(negedge gClk);
        reset_n = 1'b1;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_left   = '0;
        in_right  = '0;
        mute_req  = 1'b0;
        hp_detect = 1'b0;
        model_reset();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge gClk);
        check_reset_state("por");
        reset_n = 1'b1;

        // Fade-in from reset, one sample every 4 cycles.
        clear_logs();
        for (int i = 0; i < 260; i++) send(16'h4000, 16'hFFFF, 2);
        chk("t1 count", log_l0.size(), 32'd260);
        chk("t1 out0",   {16'b0, log_l0[0]},   32'h0000);
        chk("t1 out1",   {16'b0, log_l0[1]},   32'h0000);
        chk("t1 out2",   {16'b0, log_l0[2]},   32'h0040);
        chk("t1 out3",   {16'b0, log_l0[3]},   32'h0080);
        chk("t1 out256", {16'b0, log_l0[256]}, 32'h3FC0);
        chk("t1 out257", {16'b0, log_l0[257]}, 32'h4000);
        chk("t1 muted0", {31'b0, log_m0[0]},   32'd0);
        chk("t4 neg1 at gain 128", {16'b0, log_r0[129]}, 32'hFFFF);

        // Full-scale extremes at unity.
        clear_logs();
        send(16'h8000, 16'h7FFF, 0);
        chk("t4 8000 unity", {16'b0, log_l0[0]}, 32'h8000);
        chk("t4 7FFF unity", {16'b0, log_r0[0]}, 32'h7FFF);

        // Headphone insert: fade out, flip route at zero, hold, fade in.
        clear_logs();
        hp_detect = 1'b1;
        for (int i = 0; i < 530; i++) send(16'h4000, 16'h1234, 0);
        chk("t3 last gain1",   {16'b0, log_l0[256]}, 32'h0040);
        chk("t3 first zero",   {16'b0, log_l0[257]}, 32'h0000);
        chk("t3 last zero",    {16'b0, log_l0[263]}, 32'h0000);
        chk("t3 fade-in 1",    {16'b0, log_l0[264]}, 32'h0040);
        chk("t3 route before", {31'b0, log_rt0[256]}, 32'd0);
        chk("t3 route flip",   {31'b0, log_rt0[257]}, 32'd1);
        chk("t3 hold muted",   {31'b0, log_m0[261]},  32'd1);
        chk("t3 unity again",  {16'b0, log_l0[529]}, 32'h4000);

        // Reset mid-ramp, then ramp restarts from gain 0.
        hp_detect = 1'b0;
        reset_pulse("t5a");
        for (int i = 0; i < 50; i++) send(16'h4000, 16'h0100, 0);
        reset_pulse("t5b");
        clear_logs();
        for (int i = 0; i < 101; i++) send(16'h4000, 16'h0100, 0);
        chk("t5 restart0", {16'b0, log_l0[0]}, 32'h0000);
        chk("t5 restart1", {16'b0, log_l0[1]}, 32'h0000);
        chk("t5 restart2", {16'b0, log_l0[2]}, 32'h0040);

        // Mute at gain 100: smooth reversal.
        clear_logs();
        mute_req = 1'b1;
        for (int i = 0; i < 4; i++) send(16'h4000, 16'h0100, 0);
        chk("t2 g100 a", {16'b0, log_l0[0]}, 32'h1900);
        chk("t2 g100 b", {16'b0, log_l0[1]}, 32'h1900);
        chk("t2 g99",    {16'b0, log_l0[2]}, 32'h18C0);
        chk("t2 g98",    {16'b0, log_l0[3]}, 32'h1880);
        for (int i = 0; i < 110; i++) send(16'h4000, 16'h0100, 0);
        chk("t2 muted", {31'b0, bus0.muted},    32'd1);
        chk("t2 zero",  {16'b0, bus0.out_left}, 32'h0000);

        // Headphone blip before zero gain: ramp reverses, route untouched.
        mute_req = 1'b0;
        for (int i = 0; i < 60; i++) send(16'h2000, 16'hE000, 0);
        hp_detect = 1'b1;
        for (int i = 0; i < 10; i++) send(16'h2000, 16'hE000, 0);
        hp_detect = 1'b0;
        for (int i = 0; i < 20; i++) send(16'h2000, 16'hE000, 0);
        chk("blip route", {31'b0, bus0.hp_route}, 32'd0);
        chk("blip muted", {31'b0, bus0.muted},    32'd0);

        // Mute and headphone change together: flip at zero, stay muted.
        mute_req  = 1'b1;
        hp_detect = 1'b1;
        for (int i = 0; i < 100; i++) send(16'h2000, 16'hE000, 0);
        chk("both route", {31'b0, bus0.hp_route}, 32'd1);
        chk("both muted", {31'b0, bus0.muted},    32'd1);
        chk("both zero",  {16'b0, bus0.out_left}, 32'h0000);

        // Continuous in_valid with the step-4 instance.
        clear_logs();
        mute_req = 1'b0;
        stream(16'h4000, 16'hC000, 80);
        chk("t6 count", log_l4.size(), 32'd80);
        chk("t6 gain4",   {16'b0, log_l4[2]},  32'h0100);
        chk("t6 gain252", {16'b0, log_l4[64]}, 32'h3F00);
        chk("t6 unity",   {16'b0, log_l4[65]}, 32'h4000);

        repeat (3) @(negedge gClk);
        chk("sb0 drained", sb0.size(), 32'd0);
        chk("sb4 drained", sb4.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
